// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store issue controller
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } lsu_state_e;

  localparam logic [1:0] OP_MODE1_LOAD  = 2'b00;
  localparam logic [1:0] OP_MODE1_STORE = 2'b01;

  localparam logic [2:0] OP_MODE2_B  = 3'b000;
  localparam logic [2:0] OP_MODE2_H  = 3'b010;
  localparam logic [2:0] OP_MODE2_W  = 3'b100;
  localparam logic [2:0] OP_MODE2_BU = 3'b001;
  localparam logic [2:0] OP_MODE2_HU = 3'b011;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/lsu_funct3_decode.sv
// rtl/lsu_funct3_decode.sv - maps RISC-V funct3 to RAM width code, size and legality
module lsu_funct3_decode
  import lsu_pkg::*;
(
  input  logic       is_store_i,
  input  logic [2:0] funct3_i,
  output logic [2:0] op_mode2_o,
  output logic [1:0] size_o,
  output logic       illegal_o
);

  // Stores only know the signed widths; unsigned variants are load-only
  always_comb begin
    op_mode2_o = OP_MODE2_B;
    size_o     = SIZE_B;
    illegal_o  = 1'b0;
    unique case (funct3_i)
      FUNCT3_B:  begin op_mode2_o = OP_MODE2_B;  size_o = SIZE_B; end
      FUNCT3_H:  begin op_mode2_o = OP_MODE2_H;  size_o = SIZE_H; end
      FUNCT3_W:  begin op_mode2_o = OP_MODE2_W;  size_o = SIZE_W; end
      FUNCT3_BU: begin op_mode2_o = OP_MODE2_BU; size_o = SIZE_B; illegal_o = is_store_i; end
      FUNCT3_HU: begin op_mode2_o = OP_MODE2_HU; size_o = SIZE_H; illegal_o = is_store_i; end
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_issue_ctrl.sv
// rtl/lsu_issue_ctrl.sv - single-outstanding load/store issue FSM toward the data RAM (option: LSU_MISALIGN_CHECK_EN)
module lsu_issue_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_is_store_i,
  input  logic [2:0]  in_funct3_i,
  input  logic [31:0] in_base_i,
  input  logic [31:0] in_src_i,
  input  logic [31:0] in_imm_i,
  input  logic [4:0]  in_rd_i,
  output logic        mem_start_o,
  output logic [1:0]  mem_use_part_o,
  output logic [1:0]  mem_op_mode1_o,
  output logic [2:0]  mem_op_mode2_o,
  output logic [31:0] mem_op1_o,
  output logic [31:0] mem_op2_o,
  output logic [31:0] mem_imm_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_res_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        st_done_o,
  output logic        err_o
);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, mem_start_q, wb_valid_q, st_done_q, err_q, is_store_q;
  logic [1:0]       op_mode1_q;
  logic [2:0]       op_mode2_q;
  logic [31:0]      op1_q, op2_q, imm_q, wb_data_q;
  logic [4:0]       rd_q;

  logic [2:0]       dec_mode2;
  logic [1:0]       dec_size;
  logic             dec_illegal;
  logic             misalign;

  lsu_funct3_decode u_decode (
    .is_store_i (in_is_store_i),
    .funct3_i   (in_funct3_i),
    .op_mode2_o (dec_mode2),
    .size_o     (dec_size),
    .illegal_o  (dec_illegal)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  logic [31:0] ea;
  assign ea       = in_base_i + in_imm_i;
  assign misalign = ((dec_size == SIZE_H) && ea[0]) ||
                    ((dec_size == SIZE_W) && (ea[1:0] != 2'b00));
`else
  logic unused_size;
  assign unused_size = ^dec_size;
  assign misalign    = 1'b0;
`endif

  // Request sequencer: all handshake pulses are registered and last one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      st_done_q   <= 1'b0;
      err_q       <= 1'b0;
      is_store_q  <= 1'b0;
      op_mode1_q  <= OP_MODE1_LOAD;
      op_mode2_q  <= OP_MODE2_B;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      wb_data_q   <= '0;
    end else begin
      mem_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      st_done_q   <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            is_store_q <= in_is_store_i;
            op_mode1_q <= in_is_store_i ? OP_MODE1_STORE : OP_MODE1_LOAD;
            op_mode2_q <= dec_mode2;
            op1_q      <= in_base_i;
            op2_q      <= in_src_i;
            imm_q      <= in_imm_i;
            rd_q       <= in_rd_i;
            in_ready_q <= 1'b0;
            if (dec_illegal || misalign) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              mem_start_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the timeout cycle is still honoured
          if (mem_done_i) begin
            state_q <= ST_RESP;
            if (is_store_q) begin
              st_done_q <= 1'b1;
            end else begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= (rd_q == 5'd0) ? 32'd0 : mem_res_i;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP, ST_ERR: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign mem_start_o    = mem_start_q;
  assign mem_use_part_o = 2'b00;
  assign mem_op_mode1_o = op_mode1_q;
  assign mem_op_mode2_o = op_mode2_q;
  assign mem_op1_o      = op1_q;
  assign mem_op2_o      = op2_q;
  assign mem_imm_o      = imm_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = rd_q;
  assign wb_data_o      = wb_data_q;
  assign st_done_o      = st_done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_lsu_issue_ctrl.sv
// tb/tb_lsu_issue_ctrl.sv - directed self-checking bench for lsu_issue_ctrl
module tb_lsu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_is_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_base = '0, in_src = '0, in_imm = '0;
  logic [4:0]  in_rd = '0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_res = '0;
  logic        in_ready, mem_start, wb_valid, st_done, err;
  logic [1:0]  mem_use_part, mem_op_mode1;
  logic [2:0]  mem_op_mode2;
  logic [31:0] mem_op1, mem_op2, mem_imm, wb_data;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  int          ev_lat, ev_starts;
  logic        ev_wbv, ev_std, ev_err;
  logic [1:0]  ev_m1;
  logic [2:0]  ev_m2;
  logic [31:0] ev_op1, ev_op2, ev_imm, ev_data;
  logic [4:0]  ev_rd;

  always #5 clk = ~clk;

  lsu_issue_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_is_store_i(in_is_store), .in_funct3_i(in_funct3),
    .in_base_i(in_base), .in_src_i(in_src), .in_imm_i(in_imm), .in_rd_i(in_rd),
    .mem_start_o(mem_start), .mem_use_part_o(mem_use_part),
    .mem_op_mode1_o(mem_op_mode1), .mem_op_mode2_o(mem_op_mode2),
    .mem_op1_o(mem_op1), .mem_op2_o(mem_op2), .mem_imm_o(mem_imm),
    .mem_done_i(mem_done), .mem_res_i(mem_res),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .st_done_o(st_done), .err_o(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge and follow it until its response pulse.
  // Cycle k counts from the accept cycle (k=0); WAIT begins at k=2.
  // done_after = WAIT cycles before mem_done is raised, -1 = never.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] src, input logic [31:0] imm, input logic [4:0] rd,
                         input int done_after, input logic [31:0] res);
    ev_lat = 0; ev_starts = 0; ev_wbv = 0; ev_std = 0; ev_err = 0;
    ev_m1 = '1; ev_m2 = '1; ev_op1 = '0; ev_op2 = '0; ev_imm = '0; ev_data = '0; ev_rd = '0;
    in_is_store = st; in_funct3 = f3; in_base = base; in_src = src; in_imm = imm; in_rd = rd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_start) begin
        ev_starts++;
        ev_m1 = mem_op_mode1; ev_m2 = mem_op_mode2;
        ev_op1 = mem_op1; ev_op2 = mem_op2; ev_imm = mem_imm;
      end
      if (wb_valid || st_done || err) begin
        ev_lat = k; ev_wbv = wb_valid; ev_std = st_done; ev_err = err;
        ev_data = wb_data; ev_rd = wb_rd;
        break;
      end
      mem_done = (done_after >= 0) && (k == 2 + done_after);
      mem_res  = res;
      @(negedge clk);
    end
    mem_done = 1'b0;
    if (ev_lat == 0) check_eq("response_within_bound", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("ready_after_resp", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #12;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_pulses", {28'd0, mem_start, wb_valid, st_done, err}, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LW rs1=0x100 imm=4 rd=5, done in second WAIT cycle
    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'd4, 5'd5, 1, 32'hDEADBEEF);
    check_eq("lw_starts", 32'(ev_starts), 32'd1);
    check_eq("lw_mode1", {30'd0, ev_m1}, 32'd0);
    check_eq("lw_mode2", {29'd0, ev_m2}, 32'b100);
    check_eq("lw_op1", ev_op1, 32'h100);
    check_eq("lw_imm", ev_imm, 32'd4);
    check_eq("lw_lat", 32'(ev_lat), 32'd4);
    check_eq("lw_pulses", {29'd0, ev_wbv, ev_std, ev_err}, 32'b100);
    check_eq("lw_rd", {27'd0, ev_rd}, 32'd5);
    check_eq("lw_data", ev_data, 32'hDEADBEEF);

    // LBU with immediate done
    run_req(1'b0, 3'b100, 32'h200, 32'h0, 32'd1, 5'd7, 0, 32'h000000AB);
    check_eq("lbu_mode2", {29'd0, ev_m2}, 32'b001);
    check_eq("lbu_lat", 32'(ev_lat), 32'd3);
    check_eq("lbu_data", ev_data, 32'h000000AB);

    // LH
    run_req(1'b0, 3'b001, 32'h300, 32'h0, 32'd2, 5'd9, 0, 32'hFFFF8001);
    check_eq("lh_mode2", {29'd0, ev_m2}, 32'b010);
    check_eq("lh_data", ev_data, 32'hFFFF8001);

    // SH
    run_req(1'b1, 3'b001, 32'h400, 32'h1234, 32'd6, 5'd0, 2, 32'h0);
    check_eq("sh_mode1", {30'd0, ev_m1}, 32'b01);
    check_eq("sh_mode2", {29'd0, ev_m2}, 32'b010);
    check_eq("sh_op2", ev_op2, 32'h1234);
    check_eq("sh_pulses", {29'd0, ev_wbv, ev_std, ev_err}, 32'b010);
    check_eq("sh_lat", 32'(ev_lat), 32'd5);

    // Timeout: 16 WAIT cycles from k=2 -> err at k=18
    run_req(1'b0, 3'b010, 32'h500, 32'h0, 32'd0, 5'd3, -1, 32'h0);
    check_eq("to_pulses", {29'd0, ev_wbv, ev_std, ev_err}, 32'b001);
    check_eq("to_lat", 32'(ev_lat), 32'd18);
    check_eq("to_starts", 32'(ev_starts), 32'd1);

    // Done on the timeout cycle wins
    run_req(1'b0, 3'b010, 32'h500, 32'h0, 32'd0, 5'd3, 15, 32'h5A5A0000);
    check_eq("edge_pulses", {29'd0, ev_wbv, ev_std, ev_err}, 32'b100);
    check_eq("edge_lat", 32'(ev_lat), 32'd18);

    // Illegal load funct3 011 and store funct3 100
    run_req(1'b0, 3'b011, 32'h0, 32'h0, 32'd0, 5'd1, 0, 32'h0);
    check_eq("ill_ld_err", {29'd0, ev_wbv, ev_std, ev_err}, 32'b001);
    check_eq("ill_ld_lat", 32'(ev_lat), 32'd1);
    check_eq("ill_ld_starts", 32'(ev_starts), 32'd0);
    run_req(1'b1, 3'b100, 32'h0, 32'h0, 32'd0, 5'd1, 0, 32'h0);
    check_eq("ill_st_err", {29'd0, ev_wbv, ev_std, ev_err}, 32'b001);
    check_eq("ill_st_starts", 32'(ev_starts), 32'd0);

    // LW at ea=0x102
    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'd2, 5'd4, 0, 32'h11223344);
`ifdef LSU_MISALIGN_CHECK_EN
    check_eq("mis_pulses", {29'd0, ev_wbv, ev_std, ev_err}, 32'b001);
    check_eq("mis_starts", 32'(ev_starts), 32'd0);
`else
    check_eq("mis_pulses", {29'd0, ev_wbv, ev_std, ev_err}, 32'b100);
    check_eq("mis_starts", 32'(ev_starts), 32'd1);
    check_eq("mis_data", ev_data, 32'h11223344);
`endif

    // Load to x0 still pulses wb_valid with zero data
    run_req(1'b0, 3'b010, 32'h600, 32'h0, 32'd0, 5'd0, 0, 32'hCAFEF00D);
    check_eq("x0_pulses", {29'd0, ev_wbv, ev_std, ev_err}, 32'b100);
    check_eq("x0_data", ev_data, 32'd0);

    // mem_done while idle is ignored
    mem_done = 1'b1; mem_res = 32'h77777777;
    @(negedge clk);
    mem_done = 1'b0;
    check_eq("idle_done_pulses", {29'd0, wb_valid, st_done, err}, 32'd0);
    check_eq("idle_done_ready", {31'd0, in_ready}, 32'd1);

    // Reset asserted mid-WAIT
    in_is_store = 1'b0; in_funct3 = 3'b010; in_base = 32'h700; in_imm = 32'd0; in_rd = 5'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rw_start", {31'd0, mem_start}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rw_async_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rw_async_op1", mem_op1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_done = 1'b1; mem_res = 32'h12345678;
    @(negedge clk);
    mem_done = 1'b0;
    @(negedge clk);
    check_eq("rw_no_pulses", {28'd0, mem_start, wb_valid, st_done, err}, 32'd0);
    check_eq("rw_ready", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
